// File: rtl/bit_rev_reorder_ctrl.sv
// Frame buffer that accepts INDEX samples in natural order and replays them
// in bit-reversed index order, ahead of the first FFT butterfly stage.
module bit_rev_reorder_ctrl #(
    parameter int INDEX = 8,
    parameter int M     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    output logic [M-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         frame_err
);

    localparam int ADDR_W = $clog2(INDEX);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(INDEX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [M-1:0]        out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                in_ready_q, in_ready_d;
    logic                frame_err_q, frame_err_d;
    logic                wr_en;
    logic                in_xfer;
    logic                out_xfer;
    logic                final_wr;
    logic [M-1:0]        mem_q [INDEX];

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;
        final_wr    = 1'b0;
        in_xfer     = in_valid & in_ready_q;
        out_xfer    = out_valid_q & out_ready;

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    wr_en       = 1'b1;
                    wr_cnt_d    = ADDR_W'(1);
                    state_d     = LOAD;
                    frame_err_d = in_last;
                end
            end
            LOAD: begin
                if (in_xfer) begin
                    wr_en       = 1'b1;
                    final_wr    = (wr_cnt_q == LAST_IDX);
                    // in_last must coincide exactly with the final slot
                    frame_err_d = in_last ^ final_wr;
                    if (final_wr) begin
                        wr_cnt_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_xfer && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    rd_cnt_d    = '0;
                    state_d     = IDLE;
                end else if (!out_valid_q || out_ready) begin
                    out_data_d  = mem_q[bitrev(rd_cnt_q)];
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_cnt_q == LAST_IDX);
                    rd_cnt_d    = rd_cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so it reads 0 while in reset and rises one cycle later
        in_ready_d = (state_d != DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Sample storage carries no reset; contents are only read after a full load
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_cnt_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bit_rev_reorder_ctrl.sv
// Bench for bit_rev_reorder_ctrl: directed and randomized frames on an
// INDEX=8 and an INDEX=4 instance, checked against a bit-reversal reference.
module tb_bit_rev_reorder_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] i8_data, o8_data, i4_data, o4_data;
    logic       i8_valid, i8_ready, i8_last, o8_valid, o8_ready, o8_last, busy8, ferr8;
    logic       i4_valid, i4_ready, i4_last, o4_valid, o4_ready, o4_last, busy4, ferr4;

    int tests = 0;
    int fails = 0;

    bit_rev_reorder_ctrl #(.INDEX(8), .M(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_data(i8_data), .in_valid(i8_valid), .in_ready(i8_ready), .in_last(i8_last),
        .out_data(o8_data), .out_valid(o8_valid), .out_ready(o8_ready), .out_last(o8_last),
        .busy(busy8), .frame_err(ferr8)
    );

    bit_rev_reorder_ctrl #(.INDEX(4), .M(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_data(i4_data), .in_valid(i4_valid), .in_ready(i4_ready), .in_last(i4_last),
        .out_data(o4_data), .out_valid(o4_valid), .out_ready(o4_ready), .out_last(o4_last),
        .busy(busy4), .frame_err(ferr4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference bit reversal by repeated halving of the index
    function automatic int rev(input int x, input int bits);
        int r = 0;
        int v = x;
        for (int b = 0; b < bits; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic logic [7:0] g_odata(input int w);
        return (w == 4) ? o4_data : o8_data;
    endfunction
    function automatic logic g_ovalid(input int w);
        return (w == 4) ? o4_valid : o8_valid;
    endfunction
    function automatic logic g_olast(input int w);
        return (w == 4) ? o4_last : o8_last;
    endfunction
    function automatic logic g_iready(input int w);
        return (w == 4) ? i4_ready : i8_ready;
    endfunction
    function automatic logic g_busy(input int w);
        return (w == 4) ? busy4 : busy8;
    endfunction
    function automatic logic g_ferr(input int w);
        return (w == 4) ? ferr4 : ferr8;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int w, input logic v, input logic [7:0] d, input logic l);
        if (w == 4) begin
            i4_valid = v; i4_data = d; i4_last = l;
        end else begin
            i8_valid = v; i8_data = d; i8_last = l;
        end
    endtask

    task automatic set_ready(input int w, input logic r);
        if (w == 4) o4_ready = r;
        else        o8_ready = r;
    endtask

    task automatic make_seq(output logic [7:0] q[$], input int base, input int n);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'(base + i));
    endtask

    task automatic drive_frame(input int w, input logic [7:0] fr[$], input int gap,
                               input int last_at, input int count);
        int n;
        int t;
        n = (w == 4) ? 4 : 8;
        for (int i = 0; i < count; i++) begin
            set_in(w, 1'b1, fr[i], (i == last_at));
            t = 0;
            while (!g_iready(w) && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) begin
                chk("in_ready_timeout", 32'(t), 32'(0));
                set_in(w, 1'b0, 8'd0, 1'b0);
                return;
            end
            step();
            set_in(w, 1'b0, 8'd0, 1'b0);
            chk($sformatf("frame_err_at_%0d", i), 32'(g_ferr(w)),
                32'((i == last_at) != (i == n - 1)));
            if (i < n - 1) begin
                repeat (gap) begin
                    step();
                    chk("frame_err_one_cycle", 32'(g_ferr(w)), 32'(0));
                end
            end
        end
    endtask

    // mode 0: ready held high, 1: ready toggles, 2: random ready
    task automatic drain(input int w, input logic [7:0] fr[$], input int mode);
        int n, bits, k, cyc, first;
        logic r;
        logic [7:0] hd;
        logic hl;
        logic [7:0] exp_q[$];
        n = (w == 4) ? 4 : 8;
        bits = (w == 4) ? 2 : 3;
        exp_q = {};
        for (int i = 0; i < n; i++) exp_q.push_back(fr[rev(i, bits)]);
        chk("drain_entry_valid", 32'(g_ovalid(w)), 32'(0));
        chk("drain_entry_in_ready", 32'(g_iready(w)), 32'(0));
        chk("drain_entry_busy", 32'(g_busy(w)), 32'(1));
        k = 0;
        cyc = 0;
        first = -1;
        while (k < n && cyc < 300) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            set_ready(w, r);
            if (g_ovalid(w)) begin
                if (first < 0) begin
                    first = cyc;
                    if (mode == 0) chk("first_valid_latency", 32'(cyc), 32'(1));
                end
                if (r) begin
                    chk($sformatf("out_data_%0d", k), 32'(g_odata(w)), 32'(exp_q[k]));
                    chk($sformatf("out_last_%0d", k), 32'(g_olast(w)), 32'(k == n - 1));
                    k++;
                    step();
                end else begin
                    hd = g_odata(w);
                    hl = g_olast(w);
                    step();
                    chk("hold_valid", 32'(g_ovalid(w)), 32'(1));
                    chk("hold_data", 32'(g_odata(w)), 32'(hd));
                    chk("hold_last", 32'(g_olast(w)), 32'(hl));
                end
            end else begin
                if (mode == 0 && first >= 0) chk("stream_gap_valid", 32'(g_ovalid(w)), 32'(1));
                step();
            end
            cyc++;
        end
        if (k < n) chk("drain_timeout", 32'(k), 32'(n));
        set_ready(w, 1'b0);
        chk("end_out_valid", 32'(g_ovalid(w)), 32'(0));
        chk("end_in_ready", 32'(g_iready(w)), 32'(1));
        chk("end_busy", 32'(g_busy(w)), 32'(0));
    endtask

    task automatic chk_reset_outputs(input int w);
        chk("rst_out_data", 32'(g_odata(w)), 32'(0));
        chk("rst_out_valid", 32'(g_ovalid(w)), 32'(0));
        chk("rst_out_last", 32'(g_olast(w)), 32'(0));
        chk("rst_in_ready", 32'(g_iready(w)), 32'(0));
        chk("rst_busy", 32'(g_busy(w)), 32'(0));
        chk("rst_frame_err", 32'(g_ferr(w)), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];
        rst_n = 1'b1;
        set_in(8, 1'b0, 8'd0, 1'b0);
        set_in(4, 1'b0, 8'd0, 1'b0);
        o8_ready = 1'b0;
        o4_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs(8);
        chk_reset_outputs(4);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_in_ready", 32'(i8_ready), 32'(1));
        chk("post_reset_busy", 32'(busy8), 32'(0));

        // Back-to-back frame, ready held high
        make_seq(fr, 0, 8);
        drive_frame(8, fr, 0, 7, 8);
        drain(8, fr, 0);

        // Same frame, toggling ready
        drive_frame(8, fr, 0, 7, 8);
        drain(8, fr, 1);

        // Valid every third cycle
        make_seq(fr, 10, 8);
        drive_frame(8, fr, 2, 7, 8);
        drain(8, fr, 0);

        // Early in_last on the 4th sample
        make_seq(fr, 32, 8);
        drive_frame(8, fr, 1, 3, 8);
        drain(8, fr, 0);

        // Asynchronous reset in the middle of a load
        make_seq(fr, 64, 8);
        drive_frame(8, fr, 0, -1, 5);
        chk("mid_busy_before_reset", 32'(busy8), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs(8);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mid_reset_in_ready", 32'(i8_ready), 32'(1));
        chk("mid_reset_busy", 32'(busy8), 32'(0));
        make_seq(fr, 0, 8);
        drive_frame(8, fr, 0, 7, 8);
        drain(8, fr, 0);

        // INDEX=4: two consecutive frames
        make_seq(fr, 1, 4);
        drive_frame(4, fr, 0, 3, 4);
        drain(4, fr, 0);
        make_seq(fr, 5, 4);
        drive_frame(4, fr, 0, 3, 4);
        drain(4, fr, 0);

        // Randomized frames, gaps and backpressure
        for (int f = 0; f < 4; f++) begin
            fr = {};
            for (int i = 0; i < 8; i++) fr.push_back(8'($urandom_range(0, 255)));
            drive_frame(8, fr, int'($urandom_range(0, 2)), 7, 8);
            drain(8, fr, 2);
        end
        for (int f = 0; f < 3; f++) begin
            fr = {};
            for (int i = 0; i < 4; i++) fr.push_back(8'($urandom_range(0, 255)));
            drive_frame(4, fr, int'($urandom_range(0, 2)), 3, 4);
            drain(4, fr, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
